// File: rtl/conv_out_requant.sv
// Per-row requantizer: bias add, rounding arithmetic right shift and clamp to OW-bit activations.
// Define REQ_RELU_EN to clamp to [0, 2^(OW-1)-1]; otherwise outputs saturate to the signed OW-bit range.
module conv_out_requant #(
    parameter int DW     = 32,
    parameter int DP     = 56,
    parameter int OW     = 8,
    parameter int SHW    = 5,
    parameter int CH_NUM = 64,
    parameter int CHW    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW*DP-1:0]   data_i,
    input  logic               row_last,
    input  logic [SHW-1:0]     shift,
    input  logic               bias_we,
    input  logic [CHW-1:0]     bias_addr,
    input  logic [DW-1:0]      bias_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW*DP-1:0]   data_o,
    output logic [CHW-1:0]     out_ch,
    output logic               out_last
);

    localparam logic [CHW-1:0]      CH_MAX = CHW'(CH_NUM - 1);
    localparam logic [CHW:0]        CH_LIM = (CHW+1)'(CH_NUM);
    localparam logic signed [DW+1:0] ONE   = (DW+2)'(1);
    localparam logic signed [DW+1:0] HI    = (DW+2)'((1 << (OW-1)) - 1);
`ifdef REQ_RELU_EN
    localparam logic signed [DW+1:0] LO    = '0;
`else
    localparam logic signed [DW+1:0] LO    = -((DW+2)'(1 << (OW-1)));
`endif

    logic                    en;
    logic                    accept;
    logic [DW-1:0]           bias [CH_NUM];
    logic [CHW-1:0]          ch_cnt;
    logic [DW-1:0]           b;

    logic                    v1;
    logic [SHW-1:0]          sh1;
    logic [CHW-1:0]          ch1;
    logic                    last1;
    logic [DW:0]             s1   [DP];
    logic [DW:0]             s1_d [DP];

    logic                    v2;
    logic [CHW-1:0]          ch2;
    logic                    last2;
    logic signed [DW+1:0]    s2   [DP];
    logic signed [DW+1:0]    s2_d [DP];
    logic signed [DW+1:0]    rnd;
    logic signed [DW+1:0]    sum;

    logic [OW*DP-1:0]        d3;

    // Global stall: every stage advances only when the output register can move.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign b        = bias[ch_cnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH_NUM; i++) bias[i] <= '0;
        end else if (bias_we && ({1'b0, bias_addr} < CH_LIM)) begin
            bias[bias_addr] <= bias_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt <= '0;
        end else if (accept && row_last) begin
            ch_cnt <= (ch_cnt == CH_MAX) ? '0 : ch_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned m = 0; m < DP; m++) begin
            s1_d[m] = {data_i[DW*m + DW - 1], data_i[DW*m +: DW]} + {b[DW-1], b};
        end
    end

    // Half-up rounding: add 2^(shift-1) before the arithmetic shift.
    always_comb begin
        sum = '0;
        rnd = (sh1 == '0) ? '0 : (ONE << (sh1 - 1'b1));
        for (int unsigned m = 0; m < DP; m++) begin
            sum     = {s1[m][DW], s1[m]} + rnd;
            s2_d[m] = sum >>> sh1;
        end
    end

    always_comb begin
        d3 = '0;
        for (int unsigned m = 0; m < DP; m++) begin
            if (s2[m] > HI) begin
                d3[OW*m +: OW] = HI[OW-1:0];
            end else if (s2[m] < LO) begin
                d3[OW*m +: OW] = LO[OW-1:0];
            end else begin
                d3[OW*m +: OW] = s2[m][OW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            sh1       <= '0;
            ch1       <= '0;
            last1     <= 1'b0;
            v2        <= 1'b0;
            ch2       <= '0;
            last2     <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            data_o    <= '0;
            for (int unsigned m = 0; m < DP; m++) begin
                s1[m] <= '0;
                s2[m] <= '0;
            end
        end else if (en) begin
            v1        <= in_valid;
            sh1       <= shift;
            ch1       <= ch_cnt;
            last1     <= row_last;
            v2        <= v1;
            ch2       <= ch1;
            last2     <= last1;
            out_valid <= v2;
            out_ch    <= ch2;
            out_last  <= last2;
            data_o    <= d3;
            for (int unsigned m = 0; m < DP; m++) begin
                s1[m] <= s1_d[m];
                s2[m] <= s2_d[m];
            end
        end
    end

endmodule

// File: tb/tb_conv_out_requant.sv
// Directed bench for conv_out_requant: latency, rounding, clamp, backpressure, channel wrap, reset.
module tb_conv_out_requant;

    localparam int DW = 32, DP = 56, OW = 8, SHW = 5, CH_NUM = 64, CHW = 6;
`ifdef REQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DW*DP-1:0]   data_i;
    logic               row_last;
    logic [SHW-1:0]     shift;
    logic               bias_we;
    logic [CHW-1:0]     bias_addr;
    logic [DW-1:0]      bias_data;
    logic               out_valid;
    logic               out_ready;
    logic [OW*DP-1:0]   data_o;
    logic [CHW-1:0]     out_ch;
    logic               out_last;

    conv_out_requant #(
        .DW(DW), .DP(DP), .OW(OW), .SHW(SHW), .CH_NUM(CH_NUM), .CHW(CHW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_i(data_i), .row_last(row_last), .shift(shift),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
        .out_ch(out_ch), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW*DP-1:0] d;
        logic [CHW-1:0]   ch;
        logic             last;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Every retired output (valid && ready at the coming edge) is captured here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) q.push_back({data_o, out_ch, out_last});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [OW*DP-1:0] d, input int m);
        return d[OW*m +: OW];
    endfunction

    task automatic send_row(input logic [31:0] l0, input logic [31:0] l1,
                            input logic [31:0] l2, input logic [31:0] l3, input logic last);
        bit acc;
        acc = 1'b0;
        data_i = '0;
        data_i[31:0]   = l0;
        data_i[63:32]  = l1;
        data_i[95:64]  = l2;
        data_i[127:96] = l3;
        row_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed in_ready 0 expected 1");
        end
        in_valid = 1'b0;
        row_last = 1'b0;
    endtask

    task automatic wait_q(input int n);
        for (int i = 0; i < 200 && q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() < n) begin
            checks++;
            errors++;
            $error("FAIL out_timeout: observed %0d rows expected %0d", q.size(), n);
        end
    endtask

    task automatic pop(output rec_t r);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pop_empty: observed 0 rows expected 1");
            r = '0;
        end else begin
            r = q.pop_front();
        end
    endtask

    task automatic wr_bias(input logic [CHW-1:0] a, input logic [DW-1:0] v);
        bias_we   = 1'b1;
        bias_addr = a;
        bias_data = v;
        @(posedge clk);
        #1;
        bias_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rec_t r;
        logic [7:0] held;
        rst_n = 1'b0; in_valid = 1'b0; data_i = '0; row_last = 1'b0; shift = '0;
        bias_we = 1'b0; bias_addr = '0; bias_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_zero", (data_o == '0), 1);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic pass, latency and clamp, shift 0, bias 0
        shift = 5'd0;
        send_row(5, -3, 200, -1000, 1'b0);
        chk("lat_c1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_c2", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_c3", out_valid, 1);
        wait_q(1);
        pop(r);
        chk("basic_l0", lane(r.d, 0), 8'h05);
        chk("basic_l1", lane(r.d, 1), RELU ? 8'h00 : 8'hFD);
        chk("basic_l2", lane(r.d, 2), 8'h7F);
        chk("basic_l3", lane(r.d, 3), RELU ? 8'h00 : 8'h80);
        chk("basic_ch", r.ch, 0);
        chk("basic_last", r.last, 0);

        // Bias and half-up rounding at channel 2, shift 4
        wr_bias(6'd2, 32'd100);
        shift = 5'd4;
        send_row(0, 0, 0, 0, 1'b1);
        send_row(0, 0, 0, 0, 1'b1);
        send_row(-60, -124, 2000, 0, 1'b0);
        wait_q(3);
        pop(r);
        chk("rnd_r0_ch", r.ch, 0);
        chk("rnd_r0_last", r.last, 1);
        chk("rnd_r0_l0", lane(r.d, 0), 8'h00);
        pop(r);
        chk("rnd_r1_ch", r.ch, 1);
        chk("rnd_r1_last", r.last, 1);
        pop(r);
        chk("rnd_l0", lane(r.d, 0), 8'h03);
        chk("rnd_l1", lane(r.d, 1), RELU ? 8'h00 : 8'hFF);
        chk("rnd_l2", lane(r.d, 2), 8'h7F);
        chk("rnd_l3", lane(r.d, 3), 8'h06);
        chk("rnd_ch", r.ch, 2);
        chk("rnd_last", r.last, 0);

        // Bias write in the same cycle as a row at that channel
        shift     = 5'd0;
        bias_we   = 1'b1;
        bias_addr = 6'd2;
        bias_data = 32'd50;
        send_row(0, 0, 0, 0, 1'b0);
        bias_we = 1'b0;
        send_row(0, 0, 0, 0, 1'b1);
        wait_q(2);
        pop(r);
        chk("coll_old", lane(r.d, 0), 8'd100);
        chk("coll_old_ch", r.ch, 2);
        pop(r);
        chk("coll_new", lane(r.d, 0), 8'd50);
        chk("coll_new_last", r.last, 1);

        // Backpressure: six rows streamed through a five-cycle output stall
        fork
            begin
                for (int i = 0; i < 6; i++) send_row(11 + i, 0, 0, 0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                held = lane(data_o, 0);
                chk("bp_head", held, 8'd11);
                repeat (4) @(negedge clk);
                chk("bp_stable", lane(data_o, 0), 8'd11);
                chk("bp_valid_held", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_q(6);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_count", q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            pop(r);
            chk("bp_order", lane(r.d, 0), 11 + i);
            chk("bp_ch", r.ch, 3);
        end

        // Channel wrap: 65 row_last rows starting from channel 3
        for (int i = 0; i < 65; i++) send_row(0, 0, 0, 0, 1'b1);
        wait_q(65);
        for (int i = 0; i < 65; i++) begin
            pop(r);
            chk("wrap_ch", r.ch, (3 + i) % CH_NUM);
        end

        // Reset with three rows in flight clears pipeline, counter and biases
        wr_bias(6'd0, 32'd77);
        send_row(1, 1, 1, 1, 1'b1);
        send_row(2, 2, 2, 2, 1'b1);
        send_row(3, 3, 3, 3, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", (data_o == '0), 1);
        chk("mid_rst_ch", out_ch, 0);
        chk("mid_rst_last", out_last, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_row(0, 0, 0, 0, 1'b0);
        wait_q(1);
        pop(r);
        chk("post_rst_bias", lane(r.d, 0), 8'h00);
        chk("post_rst_ch", r.ch, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("q_empty_end", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_requant.md
Name: conv_out_requant

Overview:
Downstream of the per-lane partial-sum accumulator. Takes one row of DP accumulated 32-bit conv sums per transfer and adds a per-output-channel bias. Then applies a rounding arithmetic right shift and activation clamp, and emits DP packed OW-bit activations to the feature-map write buffer. The datapath is a 3-stage pipeline with valid/ready flow control and a global stall.

Parameters:
DW, 32, width of each input lane (signed two's complement)
DP, 56, lanes per row
OW, 8, output activation width per lane
SHW, 5, width of the shift amount
CH_NUM, 64, bias register count (output channels per layer)
CHW, 6, channel index width, equal to clog2(CH_NUM)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_i/row_last valid
in_ready  output  1  block accepts a row this cycle
data_i  input  DW*DP  lane m at [DW*m +: DW], signed
row_last  input  1  accepted row is the last row of the current output channel
shift  input  SHW  right-shift amount; quasi-static per layer; sampled with each accepted row
bias_we  input  1  bias write strobe
bias_addr  input  CHW  bias write index
bias_data  input  DW  signed bias value
out_valid  output  1  data_o/out_ch/out_last valid
out_ready  input  1  consumer accepts output
data_o  output  OW*DP  lane m at [OW*m +: OW]
out_ch  output  CHW  channel index of the output row
out_last  output  1  row_last delayed with the row

Behaviour:
- Reset (async, rst_n=0):
  - All stage valids = 0, out_valid = 0, data_o = 0, out_ch = 0, out_last = 0.
  - Channel counter ch_cnt = 0.
  - All CH_NUM bias registers = 0.
- Pipeline enable and handshake:
  - en = !out_valid || out_ready.
  - in_ready = en (combinational from out_ready and out_valid).
  - A row is accepted when in_valid && in_ready.
  - When en=0, all stage registers hold.
  - out_valid/data_o stay stable until out_ready is high.
- Latency: an accepted row appears on data_o 3 cycles later with no stall. Full throughput is 1 row/cycle.
- Stage 1:
  - b = bias[ch_cnt]; each lane s1 = sign-extend(data_i lane) + sign-extend(b), held at DW+1 bits (no overflow possible).
  - Register shift, ch_cnt and row_last alongside.
- Channel counter:
  - Advances on an accepted row with row_last=1.
  - Wraps CH_NUM-1 -> 0.
  - Does not change on rows without row_last or on stalled cycles.
- Stage 2: per lane, s2 = (s1 + (shift==0 ? 0 : 1<<(shift-1))) >>> shift. The shift is arithmetic, the rounding is half-up, and the intermediate is DW+2 bits.
- Stage 3 clamp (REQ_RELU_EN defined): clamp s2 to [0, 2^(OW-1)-1]; negative values -> 0.
- Stage 3 clamp (REQ_RELU_EN not defined): see Optional Feature.
- Bias write:
  - When bias_we=1, bias[bias_addr] <= bias_data at the clock edge, independent of en.
  - If the write address equals ch_cnt in the same cycle a row is accepted, stage 1 uses the old value.
  - bias_addr >= CH_NUM: the write is ignored.
- Reset mid-operation: all in-flight rows are discarded and the bias registers are cleared. The upstream block must re-send.
- Simultaneous in_valid and out_ready with a full pipeline: an output is retired and a new row is accepted in the same cycle (no bubble).

Optional Feature:
REQ_RELU_EN. Defined: stage 3 applies ReLU, clamping to [0, 2^(OW-1)-1] (0..127 for OW=8). Not defined: signed saturation to [-2^(OW-1), 2^(OW-1)-1] (-128..127), giving a linear output layer. Pipeline latency and handshake are identical in both builds.

Test Plan:
- Basic pass (REQ_RELU_EN): bias[0]=0, shift=0, lane0=5, lane1=-3, lane2=200, out_ready=1 -> 3 cycles later data_o lane0=5, lane1=0, lane2=127, out_ch=0.
- Bias/round: bias[2]=100, shift=4, advance ch_cnt to 2 via two row_last rows, lane0=-60 -> (40+8)>>>4=3 on lane0, out_ch=2. Lane0=-124 -> (-24+8)>>>4=-1, giving 0 with REQ_RELU_EN and 0xFF without.
- Backpressure: stream 6 rows with out_ready=0 for cycles 4-8 -> in_ready drops once 3 rows are held, data_o stays stable, and all 6 rows emerge in order with no loss or duplication.
- Channel wrap: CH_NUM=64, send 64 rows with row_last=1 -> out_ch goes 0..63 and then 0 on the 65th row.
- Bias write collision: bias[0]=10, write bias[0]=50 in the same cycle lane0=0 is accepted at ch 0 -> output 10; the next row outputs 50.
- Reset mid-stream: assert rst_n=0 with 3 rows in flight -> out_valid=0 and data_o=0 immediately. After release, a row with bias write omitted uses bias 0.
